// File: rtl/pwm_duty_ramp_ctrl_pkg.sv
// Shared motor-drive definitions: duty width and the ramp controller state set.
package motor_pkg;

  localparam int DUTY_W = 11;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    STOP
  } ramp_st_t;

endpackage

// File: rtl/pwm_duty_ramp_ctrl_if.sv
// Target-duty command channel: valid/ready handshake carrying an 11-bit duty.
interface pwm_duty_ramp_ctrl_if;

  logic                        cmd_vld;
  logic [motor_pkg::DUTY_W-1:0] cmd_duty;
  logic                        cmd_rdy;

  modport master (
    output cmd_vld,
    output cmd_duty,
    input  cmd_rdy
  );

  modport slave (
    input  cmd_vld,
    input  cmd_duty,
    output cmd_rdy
  );

endinterface

// File: rtl/pwm_duty_ramp_ctrl_duty_step.sv
// One slew step: moves duty toward the effective target by at most step_i,
// landing exactly on the target when it is within reach. The difference is
// taken one bit wider and signed so neither direction can wrap.
module duty_step
  import motor_pkg::*;
(
  input  logic [DUTY_W-1:0] duty_i,
  input  logic [DUTY_W-1:0] eff_tgt_i,
  input  logic [DUTY_W-1:0] step_i,
  output logic [DUTY_W-1:0] duty_o
);

  logic signed [DUTY_W:0] diff;
  logic        [DUTY_W:0] mag;

  // Signed distance to target, its magnitude, then either snap or step.
  always_comb begin
    diff = $signed({1'b0, eff_tgt_i}) - $signed({1'b0, duty_i});
    mag  = diff[DUTY_W] ? $unsigned(-diff) : $unsigned(diff);
    if (mag <= {1'b0, step_i}) begin
      duty_o = eff_tgt_i;
    end else if (diff[DUTY_W]) begin
      duty_o = duty_i - step_i;
    end else begin
      duty_o = duty_i + step_i;
    end
  end

endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// Duty ramp controller for one PWM11 channel. Accepts target duties over a
// valid/ready channel and slews the applied duty toward the target, changing
// it only on PWM period boundaries and only every DIV periods.
module pwm_duty_ramp_ctrl
  import motor_pkg::*;
#(
  parameter logic [DUTY_W-1:0] STEP = 11'd16,
  parameter int                DIV  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 prd_end,
  pwm_duty_ramp_ctrl_if.slave  cmd,
  output logic [DUTY_W-1:0]    duty,
  output logic                 busy,
  output logic                 at_tgt
);

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  ramp_st_t          state_q;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] tgt_q, tgt_d;
  logic [7:0]        div_cnt_q, div_cnt_d;
  logic              busy_q;
  logic              at_tgt_q;

  logic [DUTY_W-1:0] eff_tgt;
  logic [DUTY_W-1:0] step_duty;
  logic              slew_ev;
  logic              accept;
  logic              busy_run;
  logic              busy_stop;

  assign cmd.cmd_rdy = !rst && (state_q != STOP);
  assign duty        = duty_q;
  assign busy        = busy_q;
  assign at_tgt      = at_tgt_q;

  duty_step u_step (
    .duty_i    (duty_q),
    .eff_tgt_i (eff_tgt),
    .step_i    (STEP),
    .duty_o    (step_duty)
  );

  // Datapath next values: effective target, slew event, divider, target and duty.
  always_comb begin
    eff_tgt   = (state_q == STOP) ? '0 : tgt_q;
    slew_ev   = prd_end && (div_cnt_q == DIV_LAST);
    accept    = cmd.cmd_vld && cmd.cmd_rdy;
    duty_d    = slew_ev ? step_duty : duty_q;
    tgt_d     = accept ? cmd.cmd_duty : tgt_q;
    div_cnt_d = div_cnt_q;
    if (prd_end) begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? 8'd0 : div_cnt_q + 8'd1;
    end
    busy_run  = (duty_d != tgt_d);
    busy_stop = (duty_d != '0);
  end

  // Control FSM with registered duty, target, divider, busy and at_tgt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      duty_q    <= '0;
      tgt_q     <= '0;
      div_cnt_q <= '0;
      busy_q    <= 1'b0;
      at_tgt_q  <= 1'b0;
    end else begin
      duty_q    <= duty_d;
      tgt_q     <= tgt_d;
      div_cnt_q <= div_cnt_d;
      at_tgt_q  <= 1'b0;
      busy_q    <= busy_run;
      case (state_q)
        IDLE: begin
          if (!en) begin
            state_q <= STOP;
            busy_q  <= busy_stop;
          end else if (accept && (cmd.cmd_duty != duty_q)) begin
            state_q   <= RAMP;
            div_cnt_q <= '0;
          end
        end
        RAMP: begin
          if (!en) begin
            state_q <= STOP;
            busy_q  <= busy_stop;
          end else if (slew_ev && (duty_d == tgt_d)) begin
            state_q  <= IDLE;
            at_tgt_q <= 1'b1;
          end
        end
        STOP: begin
          if (en) begin
            state_q <= (duty_d != tgt_q) ? RAMP : IDLE;
          end else begin
            busy_q <= busy_stop;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Bench for pwm_duty_ramp_ctrl: two instances (DIV=1 and DIV=4, STEP=16)
// share one stimulus stream and are compared every cycle against a
// behavioural model, with directed ramp/retarget/stop/reset sequences pinned
// by literal expectations, followed by a randomized phase.
module tb_pwm_duty_ramp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        prdEnd;
  logic        cmdVld;
  logic [10:0] cmdDuty;

  logic [10:0] dutyA, dutyB;
  logic        busyA, busyB, atA, atB;

  int checks = 0;
  int passed = 0;
  bit checkEn = 1'b0;

  pwm_duty_ramp_ctrl_if ifA ();
  pwm_duty_ramp_ctrl_if ifB ();

  assign ifA.cmd_vld  = cmdVld;
  assign ifA.cmd_duty = cmdDuty;
  assign ifB.cmd_vld  = cmdVld;
  assign ifB.cmd_duty = cmdDuty;

  pwm_duty_ramp_ctrl #(.STEP(11'd16), .DIV(1)) dutA (
    .clk(clk), .rst(rst), .en(en), .prd_end(prdEnd), .cmd(ifA.slave),
    .duty(dutyA), .busy(busyA), .at_tgt(atA)
  );

  pwm_duty_ramp_ctrl #(.STEP(11'd16), .DIV(4)) dutB (
    .clk(clk), .rst(rst), .en(en), .prd_end(prdEnd), .cmd(ifB.slave),
    .duty(dutyB), .busy(busyB), .at_tgt(atB)
  );

  always #5 clk = ~clk;

  // Behavioural model: 0 = holding at target, 1 = slewing, 2 = draining to 0.
  int divOf[2] = '{1, 4};
  int mMode[2] = '{0, 0};
  int mTgt[2]  = '{0, 0};
  int mDuty[2] = '{0, 0};
  int mCnt[2]  = '{0, 0};
  int mBusy[2] = '{0, 0};
  int mAt[2]   = '{0, 0};
  int eff, diff, nd, nt, nc, nm;
  bit ev, acc;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mMode[k] = 0; mTgt[k] = 0; mDuty[k] = 0; mCnt[k] = 0;
        mBusy[k] = 0; mAt[k] = 0;
      end else begin
        acc  = cmdVld && (mMode[k] != 2);
        eff  = (mMode[k] == 2) ? 0 : mTgt[k];
        ev   = prdEnd && (mCnt[k] == divOf[k] - 1);
        nd   = mDuty[k];
        if (ev) begin
          diff = eff - mDuty[k];
          if (diff > 16)       nd = mDuty[k] + 16;
          else if (diff < -16) nd = mDuty[k] - 16;
          else                 nd = eff;
        end
        nt = acc ? int'(cmdDuty) : mTgt[k];
        nc = prdEnd ? ((mCnt[k] + 1) % divOf[k]) : mCnt[k];
        nm = mMode[k];
        mAt[k] = 0;
        if (mMode[k] == 0) begin
          if (!en) nm = 2;
          else if (acc && int'(cmdDuty) != mDuty[k]) begin nm = 1; nc = 0; end
        end else if (mMode[k] == 1) begin
          if (!en) nm = 2;
          else if (ev && nd == nt) begin nm = 0; mAt[k] = 1; end
        end else begin
          if (en) nm = (nd != mTgt[k]) ? 1 : 0;
        end
        mMode[k] = nm; mTgt[k] = nt; mDuty[k] = nd; mCnt[k] = nc;
        mBusy[k] = (nd != ((nm == 2) ? 0 : nt)) ? 1 : 0;
      end
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("m_duty_a", dutyA, mDuty[0]);
      checkOutput("m_busy_a", busyA, mBusy[0]);
      checkOutput("m_at_a",   atA,   mAt[0]);
      checkOutput("m_rdy_a",  ifA.cmd_rdy, (!rst && mMode[0] != 2) ? 1 : 0);
      checkOutput("m_duty_b", dutyB, mDuty[1]);
      checkOutput("m_busy_b", busyB, mBusy[1]);
      checkOutput("m_at_b",   atB,   mAt[1]);
      checkOutput("m_rdy_b",  ifB.cmd_rdy, (!rst && mMode[1] != 2) ? 1 : 0);
    end
  end

  task automatic applyStimulus(input logic r, input logic e, input logic v,
                               input logic [10:0] d, input logic p);
    rst = r; en = e; cmdVld = v; cmdDuty = d; prdEnd = p;
    @(posedge clk);
    #1;
  endtask

  int rampExp[7] = '{16, 32, 48, 64, 80, 96, 100};
  int divExp[12] = '{0, 0, 0, 16, 16, 16, 16, 32, 32, 32, 32, 40};
  int retgExp[4] = '{48, 32, 20, 20};
  int expDn;
  logic enR;
  int sel;
  logic [10:0] dRand;

  initial begin
    rst = 1'b1; en = 1'b0; cmdVld = 1'b0; cmdDuty = '0; prdEnd = 1'b0;
    @(posedge clk);
    #1;
    checkEn = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_duty_a", dutyA, 0);
    checkOutput("rst_rdy_a",  ifA.cmd_rdy, 0);
    checkOutput("rst_busy_a", busyA, 0);
    checkOutput("rst_duty_b", dutyB, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("rel_rdy_a", ifA.cmd_rdy, 1);
    checkOutput("rel_rdy_b", ifB.cmd_rdy, 1);

    // Ramp up to 100 with one step per period on instance A.
    applyStimulus(0, 1, 1, 11'd100, 0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 1, 0, 0, 1);
      checkOutput("ramp_a", dutyA, rampExp[i]);
      if (i == 2) checkOutput("ramp_b_pre", dutyB, 0);
      if (i == 3) checkOutput("ramp_b_1st", dutyB, 16);
    end
    checkOutput("ramp_at_a", atA, 1);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("ramp_at_a_off", atA, 0);
    checkOutput("ramp_hold_a", dutyA, 100);

    // Divider: target 40, instance B steps every fourth period end.
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 11'd40, 0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 1, 0, 0, 1);
      checkOutput("div_b", dutyB, divExp[i]);
      if (i == 2) checkOutput("div_a", dutyA, 40);
    end
    checkOutput("div_at_b", atB, 1);

    // Retarget mid-ramp, accept coincident with a slew event.
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 11'd100, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 1);
    checkOutput("retg_start_a", dutyA, 48);
    applyStimulus(0, 1, 1, 11'd20, 1);
    checkOutput("retg_old_tgt_a", dutyA, 64);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 0, 1);
      checkOutput("retg_a", dutyA, retgExp[i]);
    end

    // Full scale, then disable: drain to 0 with commands refused.
    applyStimulus(0, 1, 1, 11'd2047, 0);
    for (int i = 0; i < 130; i++) applyStimulus(0, 1, 0, 0, 1);
    checkOutput("full_a", dutyA, 2047);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("stop_rdy_a", ifA.cmd_rdy, 0);
    for (int i = 1; i <= 128; i++) begin
      applyStimulus(0, 0, 1, 11'd5, 1);
      expDn = (i <= 127) ? 2047 - 16 * i : 0;
      checkOutput("stop_a", dutyA, expDn);
    end
    checkOutput("stop_busy_a", busyA, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("resume_busy_a", busyA, 1);
    applyStimulus(0, 1, 0, 0, 1);
    checkOutput("resume_a", dutyA, 16);

    // Reset in the middle of a ramp.
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 11'd1000, 0);
    for (int i = 0; i < 31; i++) applyStimulus(0, 1, 0, 0, 1);
    checkOutput("mid_a", dutyA, 496);
    applyStimulus(1, 1, 0, 0, 1);
    checkOutput("mid_rst_duty_a", dutyA, 0);
    checkOutput("mid_rst_at_a",   atA, 0);
    checkOutput("mid_rst_busy_a", busyA, 0);

    // Randomized phase, with sticky enable and biased duty values.
    enR = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) enR = ~enR;
      sel = $urandom_range(0, 5);
      case (sel)
        0:       dRand = 11'd0;
        1:       dRand = 11'd2047;
        2:       dRand = 11'($urandom_range(0, 40));
        default: dRand = 11'($urandom_range(0, 2047));
      endcase
      applyStimulus(($urandom_range(0, 299) == 0), enR,
                    ($urandom_range(0, 7) == 0), dRand,
                    ($urandom_range(0, 2) != 0));
    end

    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
